phys_reg_file: RTL and testbench

Parametrised multi-ported physical register file for the out-of-order core, sitting between the rename/commit stage and the issue/execute read stage. It generalises the earlier single-write, combinational-read register file:
- N write ports, N read ports, per-register ready (written) bits with allocation clearing.
- Registered reads with per-port read enable.
- Optional same-edge write-to-read bypass.

---
 rtl/phys_reg_pkg.sv | 16 +
 rtl/prf_write_merge.sv | 51 +++++
 rtl/phys_reg_file.sv | 103 ++++++++++
 tb/tb_phys_reg_file.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/phys_reg_pkg.sv
// Shared defaults and index/data types for the physical register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package phys_reg_pkg;

    localparam int PRF_DATA_W  = 32;
    localparam int PRF_N_REGS  = 64;
    localparam int PRF_IDX_W   = $clog2(PRF_N_REGS);
    localparam int PRF_N_WR    = 4;
    localparam int PRF_N_RD    = 12;
    localparam int PRF_N_ALLOC = 4;

    typedef logic [PRF_IDX_W-1:0]  preg_idx_t;
    typedef logic [PRF_DATA_W-1:0] preg_data_t;

endpackage

// File: rtl/prf_write_merge.sv
// Next-state resolver for one physical register: write-port priority plus alloc override.
// Latency: combinational.
// Backpressure: none; every enabled write/alloc is absorbed on the edge it is sampled.
//
// Ports: en (global enable), wr_en/wr_sel/wr_data (all write ports), alloc_en/alloc_sel
// (all alloc ports), cur_data/cur_rdy (present register state), nxt_data/nxt_rdy
// (state after the coming edge; also the forwarded value for a same-edge read).
module prf_write_merge
    import phys_reg_pkg::*;
#(
    parameter int          DATA_W  = PRF_DATA_W,
    parameter int          IDX_W   = PRF_IDX_W,
    parameter int          N_WR    = PRF_N_WR,
    parameter int          N_ALLOC = PRF_N_ALLOC,
    parameter int unsigned MY_IDX  = 0
) (
    input  logic                      en,
    input  logic [N_WR-1:0]           wr_en,
    input  logic [N_WR*IDX_W-1:0]     wr_sel,
    input  logic [N_WR*DATA_W-1:0]    wr_data,
    input  logic [N_ALLOC-1:0]        alloc_en,
    input  logic [N_ALLOC*IDX_W-1:0]  alloc_sel,
    input  logic [DATA_W-1:0]         cur_data,
    input  logic                      cur_rdy,
    output logic [DATA_W-1:0]         nxt_data,
    output logic                      nxt_rdy
);

    localparam logic [IDX_W-1:0] MY_SEL = IDX_W'(MY_IDX);

    always_comb begin
        nxt_data = cur_data;
        nxt_rdy  = cur_rdy;
        if (en) begin
            // Ascending scan: the last match, i.e. the highest-numbered port, wins.
            for (int k = 0; k < N_WR; k++) begin
                if (wr_en[k] && (wr_sel[k*IDX_W +: IDX_W] == MY_SEL)) begin
                    nxt_data = wr_data[k*DATA_W +: DATA_W];
                    nxt_rdy  = 1'b1;
                end
            end
            // Alloc applied after writes: a freshly allocated owner has no value yet.
            for (int j = 0; j < N_ALLOC; j++) begin
                if (alloc_en[j] && (alloc_sel[j*IDX_W +: IDX_W] == MY_SEL)) begin
                    nxt_rdy = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/phys_reg_file.sv
// Multi-ported physical register file with per-register ready bits and registered reads.
// Latency: write/alloc visible to reads sampled one edge later; read data 1 cycle after rd_sel.
// Backpressure: none; en low freezes all state and outputs.
//
// Ports: clk, reset (async, active-high), en, wr_en/wr_sel/wr_data, alloc_en/alloc_sel,
// rd_en/rd_sel, rd_data/rd_ready (registered read results, port r at slice r).
// Build option: define REGFILE_BYPASS_EN to forward same-edge writes/allocs into reads.
module phys_reg_file
    import phys_reg_pkg::*;
#(
    parameter int DATA_W  = PRF_DATA_W,
    parameter int N_REGS  = PRF_N_REGS,
    parameter int IDX_W   = $clog2(N_REGS),
    parameter int N_WR    = PRF_N_WR,
    parameter int N_RD    = PRF_N_RD,
    parameter int N_ALLOC = PRF_N_ALLOC
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [N_WR-1:0]           wr_en,
    input  logic [N_WR*IDX_W-1:0]     wr_sel,
    input  logic [N_WR*DATA_W-1:0]    wr_data,
    input  logic [N_ALLOC-1:0]        alloc_en,
    input  logic [N_ALLOC*IDX_W-1:0]  alloc_sel,
    input  logic [N_RD-1:0]           rd_en,
    input  logic [N_RD*IDX_W-1:0]     rd_sel,
    output logic [N_RD*DATA_W-1:0]    rd_data,
    output logic [N_RD-1:0]           rd_ready
);

    logic [DATA_W-1:0] pr       [N_REGS];
    logic [N_REGS-1:0] rdy;
    logic [DATA_W-1:0] nxt_data [N_REGS];
    logic [N_REGS-1:0] nxt_rdy;

    for (genvar i = 0; i < N_REGS; i++) begin : g_reg
        prf_write_merge #(
            .DATA_W  (DATA_W),
            .IDX_W   (IDX_W),
            .N_WR    (N_WR),
            .N_ALLOC (N_ALLOC),
            .MY_IDX  (i)
        ) u_merge (
            .en        (en),
            .wr_en     (wr_en),
            .wr_sel    (wr_sel),
            .wr_data   (wr_data),
            .alloc_en  (alloc_en),
            .alloc_sel (alloc_sel),
            .cur_data  (pr[i]),
            .cur_rdy   (rdy[i]),
            .nxt_data  (nxt_data[i]),
            .nxt_rdy   (nxt_rdy[i])
        );
    end

    // Architectural registers must be valid out of reset, hence rdy resets to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                pr[i] <= '0;
            end
            rdy <= '1;
        end else begin
            pr  <= nxt_data;
            rdy <= nxt_rdy;
        end
    end

    for (genvar r = 0; r < N_RD; r++) begin : g_rd
        logic [IDX_W-1:0]  sel;
        logic [DATA_W-1:0] src_data;
        logic              src_rdy;
        logic [DATA_W-1:0] data_q;
        logic              rdy_q;

        assign sel = rd_sel[r*IDX_W +: IDX_W];

`ifdef REGFILE_BYPASS_EN
        // The merged next state already folds in the winning write and alloc override.
        assign src_data = nxt_data[sel];
        assign src_rdy  = nxt_rdy[sel];
`else
        assign src_data = pr[sel];
        assign src_rdy  = rdy[sel];
`endif

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_q <= '0;
                rdy_q  <= 1'b0;
            end else if (en && rd_en[r]) begin
                data_q <= src_data;
                rdy_q  <= src_rdy;
            end
        end

        assign rd_data[r*DATA_W +: DATA_W] = data_q;
        assign rd_ready[r]                 = rdy_q;
    end

endmodule

// File: tb/tb_phys_reg_file.sv
// Directed scoreboard bench for phys_reg_file (default parameters).
// Stimulus drives on the falling edge and queues expected read results per port;
// a monitor pops and compares them just after the capturing rising edge.
module tb_phys_reg_file;

    localparam int DW  = 32;
    localparam int IW  = 6;
    localparam int NWR = 4;
    localparam int NRD = 12;
    localparam int NAL = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic [NWR-1:0]     wr_en;
    logic [NWR*IW-1:0]  wr_sel;
    logic [NWR*DW-1:0]  wr_data;
    logic [NAL-1:0]     alloc_en;
    logic [NAL*IW-1:0]  alloc_sel;
    logic [NRD-1:0]     rd_en;
    logic [NRD*IW-1:0]  rd_sel;
    logic [NRD*DW-1:0]  rd_data;
    logic [NRD-1:0]     rd_ready;

    phys_reg_file dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .alloc_en  (alloc_en),
        .alloc_sel (alloc_sel),
        .rd_en     (rd_en),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        int          port;
        logic [31:0] data;
        logic        rdy;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   edge_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every expectation tagged for the edge that just occurred.
    always @(posedge clk) begin
        edge_cnt++;
        #1;
        while (q.size() > 0 && q[0].tag <= edge_cnt) begin
            e = q.pop_front();
            chk($sformatf("rd_data[p%0d] edge %0d", e.port, e.tag),
                rd_data[e.port*DW +: DW], e.data);
            chk($sformatf("rd_ready[p%0d] edge %0d", e.port, e.tag),
                {31'b0, rd_ready[e.port]}, {31'b0, e.rdy});
        end
    end

    task automatic set_idle();
        wr_en     = '0;
        wr_sel    = '0;
        wr_data   = '0;
        alloc_en  = '0;
        alloc_sel = '0;
        rd_en     = '0;
        rd_sel    = '0;
    endtask

    task automatic wr(input int p, input int idx, input logic [31:0] d);
        logic [IW-1:0] s;
        s = IW'(idx);
        wr_en[p]            = 1'b1;
        wr_sel[p*IW +: IW]  = s;
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic alloc(input int p, input int idx);
        logic [IW-1:0] s;
        s = IW'(idx);
        alloc_en[p]           = 1'b1;
        alloc_sel[p*IW +: IW] = s;
    endtask

    // Issue a read and queue the value expected on the port after the next edge.
    task automatic rd(input int p, input int idx, input logic [31:0] d, input logic r);
        logic [IW-1:0] s;
        exp_t x;
        s = IW'(idx);
        rd_en[p]           = 1'b1;
        rd_sel[p*IW +: IW] = s;
        x.tag  = edge_cnt + 1;
        x.port = p;
        x.data = d;
        x.rdy  = r;
        q.push_back(x);
    endtask

    task automatic step();
        @(negedge clk);
        set_idle();
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        set_idle();
        #2;
        for (int p = 0; p < NRD; p++) begin
            chk($sformatf("reset rd_data[p%0d]", p), rd_data[p*DW +: DW], 32'h0);
        end
        chk("reset rd_ready", {20'b0, rd_ready}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // All ports read indices 0..11 after reset: data 0, ready 1.
        for (int p = 0; p < NRD; p++) rd(p, p, 32'h0, 1'b1);
        step();
        wr(0, 5, 32'hDEADBEEF);
        step();
        rd(2, 5, 32'hDEADBEEF, 1'b1);
        step();
        // Collision: highest-numbered port wins.
        wr(1, 9, 32'h11);
        wr(3, 9, 32'h33);
        step();
        rd(4, 9, 32'h33, 1'b1);
        step();
        alloc(0, 7);
        step();
        rd(5, 7, 32'h0, 1'b0);
        step();
        wr(2, 7, 32'h77);
        step();
        rd(5, 7, 32'h77, 1'b1);
        step();
        // Alloc and write on the same edge, with a same-edge read.
        alloc(3, 7);
        wr(0, 7, 32'h77);
`ifdef REGFILE_BYPASS_EN
        rd(6, 7, 32'h77, 1'b0);
`else
        rd(6, 7, 32'h77, 1'b1);
`endif
        step();
        rd(7, 7, 32'h77, 1'b0);
        step();
        // Same-edge write/read of idx 3 with two writers; port 2 wins.
        wr(0, 3, 32'h55);
        wr(2, 3, 32'hAA);
`ifdef REGFILE_BYPASS_EN
        rd(8, 3, 32'hAA, 1'b1);
`else
        rd(8, 3, 32'h0, 1'b1);
`endif
        step();
        rd(9, 3, 32'hAA, 1'b1);
        step();
        // en low: writes, allocs and reads all ignored; outputs hold.
        en = 1'b0;
        wr(1, 5, 32'h5555);
        alloc(1, 9);
        rd(2, 0, 32'hDEADBEEF, 1'b1);
        rd(11, 5, 32'h0, 1'b1);
        step();
        en = 1'b1;
        rd(2, 5, 32'hDEADBEEF, 1'b1);
        rd(3, 9, 32'h33, 1'b1);
        step();
        // Reset asserted between edges takes effect immediately.
        #2;
        reset = 1'b1;
        #1;
        for (int p = 0; p < NRD; p++) begin
            chk($sformatf("midreset rd_data[p%0d]", p), rd_data[p*DW +: DW], 32'h0);
        end
        chk("midreset rd_ready", {20'b0, rd_ready}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        rd(2, 5, 32'h0, 1'b1);
        rd(4, 9, 32'h0, 1'b1);
        step();

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
